// File: rtl/grid_mem_arbiter_if.sv
// Handshake and RAM bus bundle for the cell-state RAM arbiter.
// slave: the arbiter side. master: the requesters plus the RAM.
interface grid_mem_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              clear_grid;
  logic              clear_busy;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic              vga_rdata;
  logic              edit_req;
  logic [ADDR_W-1:0] edit_addr;
  logic              edit_wdata;
  logic              edit_gnt;
  logic              eng_req;
  logic              eng_we;
  logic [ADDR_W-1:0] eng_addr;
  logic              eng_wdata;
  logic              eng_gnt;
  logic              eng_rvalid;
  logic              eng_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wdata;
  logic              mem_rdata;

  modport slave (
    input  clear_grid, vga_req, vga_addr, edit_req, edit_addr, edit_wdata,
           eng_req, eng_we, eng_addr, eng_wdata, mem_rdata,
    output clear_busy, vga_gnt, vga_rvalid, vga_rdata, edit_gnt,
           eng_gnt, eng_rvalid, eng_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output clear_grid, vga_req, vga_addr, edit_req, edit_addr, edit_wdata,
           eng_req, eng_we, eng_addr, eng_wdata, mem_rdata,
    input  clear_busy, vga_gnt, vga_rvalid, vga_rdata, edit_gnt,
           eng_gnt, eng_rvalid, eng_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/grid_mem_arbiter.sv
// Single owner of the single-port cell-state RAM. A clear sweeper takes the
// RAM exclusively; otherwise VGA > edit > engine, with the engine promoted to
// the top once it has been denied STARVE_LIM cycles in a row.
module grid_mem_arbiter #(
  parameter int GRID_W     = 64,
  parameter int GRID_H     = 48,
  parameter int ADDR_W     = 12,
  parameter int STARVE_LIM = 8
) (
  input logic               clk,
  input logic               rst,
  grid_mem_arbiter_if.slave bus
);
  localparam int                CELLS = GRID_W * GRID_H;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(CELLS - 1);
  localparam int                CW    = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0]     LIM   = CW'(STARVE_LIM);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [CW-1:0]     starve_cnt;
  logic              eng_pri;
  logic [ADDR_W-1:0] addr_q;
  logic              wdata_q;
  logic              vga_rdata_q, eng_rdata_q;

  assign eng_pri = (starve_cnt == LIM) && bus.eng_req;

  // Sweeper state and pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Sweeper next state: a clear pulse (re)starts at 0 from either state
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    if (bus.clear_grid) begin
      state_nxt = CLEAR;
      ptr_nxt   = '0;
    end else if (state == CLEAR) begin
      if (ptr == LAST) state_nxt = IDLE;
      else             ptr_nxt   = ptr + 1'b1;
    end
  end

  // Grants and RAM drive; with no winner the address and data lines hold
  always_comb begin
    bus.clear_busy = (state == CLEAR);
    bus.vga_gnt    = 1'b0;
    bus.edit_gnt   = 1'b0;
    bus.eng_gnt    = 1'b0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = addr_q;
    bus.mem_wdata  = wdata_q;
    if (state == CLEAR) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = ptr;
      bus.mem_wdata = 1'b0;
    end else if (eng_pri || (bus.eng_req && !bus.vga_req && !bus.edit_req)) begin
      bus.eng_gnt   = 1'b1;
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.eng_we;
      bus.mem_addr  = bus.eng_addr;
      bus.mem_wdata = bus.eng_wdata;
    end else if (bus.vga_req) begin
      bus.vga_gnt   = 1'b1;
      bus.mem_en    = 1'b1;
      bus.mem_addr  = bus.vga_addr;
    end else if (bus.edit_req) begin
      bus.edit_gnt  = 1'b1;
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = bus.edit_addr;
      bus.mem_wdata = bus.edit_wdata;
    end
  end

  // Remember the last driven address/data so idle cycles hold them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= 1'b0;
    end else begin
      addr_q  <= bus.mem_addr;
      wdata_q <= bus.mem_wdata;
    end
  end

  // Engine starvation counter: saturates while denied, frozen during a sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           starve_cnt <= '0;
    else if (state == CLEAR)           starve_cnt <= starve_cnt;
    else if (!bus.eng_req || bus.eng_gnt) starve_cnt <= '0;
    else if (starve_cnt != LIM)        starve_cnt <= starve_cnt + 1'b1;
  end

  // Read tags: rvalid is the grant of a read, one cycle late
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.vga_rvalid <= 1'b0;
      bus.eng_rvalid <= 1'b0;
    end else begin
      bus.vga_rvalid <= bus.vga_gnt;
      bus.eng_rvalid <= bus.eng_gnt && !bus.eng_we;
    end
  end

  // Read data: RAM output passes through on rvalid and is held until the next
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_rdata_q <= 1'b0;
      eng_rdata_q <= 1'b0;
    end else begin
      vga_rdata_q <= bus.vga_rdata;
      eng_rdata_q <= bus.eng_rdata;
    end
  end

  assign bus.vga_rdata = bus.vga_rvalid ? bus.mem_rdata : vga_rdata_q;
  assign bus.eng_rdata = bus.eng_rvalid ? bus.mem_rdata : eng_rdata_q;
endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Directed bench for grid_mem_arbiter on a 4x2 grid. The stimulus process
// drives requests and posts expectations; the negedge monitor does every
// comparison, popping read-data and sweep-write queues as the DUT presents them.
module tb_grid_mem_arbiter;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  grid_mem_arbiter_if #(.ADDR_W(AW)) bus ();

  grid_mem_arbiter #(.GRID_W(4), .GRID_H(2), .ADDR_W(AW), .STARVE_LIM(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Behavioural single-port RAM, read data one cycle after an enabled read
  logic ram [16] = '{default: 1'b1};
  initial bus.mem_rdata = 1'b0;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  typedef struct { logic d; int due; } rd_t;
  rd_t vq[$];
  rd_t eq[$];
  int  mq[$];

  // Expectations posted by stimulus, consumed by the monitor
  logic [2:0]    exp_g = '0;
  logic          exp_b = 1'b0;
  logic [1:0]    exp_m = '0;
  logic [AW-1:0] exp_a = '0;
  logic chk_g = 1'b0, chk_m = 1'b0, chk_rst = 1'b0, done = 1'b0;

  int cyc_n = 0;
  int checks = 0;
  int failures = 0;
  rd_t ev, ee;
  int  ma;

  task automatic chk_v(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // Monitor: all comparisons happen here, mid-cycle
  always @(negedge clk) begin
    cyc_n++;
    if (chk_g) begin
      chk_v("grants_vga_edit_eng", {bus.vga_gnt, bus.edit_gnt, bus.eng_gnt}, exp_g);
      chk_v("clear_busy", bus.clear_busy, exp_b);
    end
    if (chk_m) begin
      chk_v("mem_en_we", {bus.mem_en, bus.mem_we}, exp_m);
      chk_v("mem_addr", bus.mem_addr, exp_a);
    end
    if (chk_rst) begin
      chk_v("rst_rvalids", {bus.vga_rvalid, bus.eng_rvalid}, 0);
      chk_v("rst_rdatas", {bus.vga_rdata, bus.eng_rdata}, 0);
      chk_v("rst_mem_wdata", bus.mem_wdata, 0);
    end
    if (bus.vga_rvalid) begin
      if (vq.size() == 0) chk_v("vga_rvalid_unexpected", 1, 0);
      else begin
        ev = vq.pop_front();
        chk_v("vga_rdata", bus.vga_rdata, ev.d);
        chk_v("vga_rvalid_cycle", cyc_n, ev.due);
      end
    end
    if (bus.eng_rvalid) begin
      if (eq.size() == 0) chk_v("eng_rvalid_unexpected", 1, 0);
      else begin
        ee = eq.pop_front();
        chk_v("eng_rdata", bus.eng_rdata, ee.d);
        chk_v("eng_rvalid_cycle", cyc_n, ee.due);
      end
    end
    if (bus.clear_busy) begin
      if (mq.size() == 0) chk_v("sweep_write_unexpected", 1, 0);
      else begin
        ma = mq.pop_front();
        chk_v("sweep_addr", bus.mem_addr, ma);
        chk_v("sweep_en_we_wdata", {bus.mem_en, bus.mem_we, bus.mem_wdata}, 3'b110);
      end
    end
    if (done) begin
      chk_v("vga_reads_outstanding", vq.size(), 0);
      chk_v("eng_reads_outstanding", eq.size(), 0);
      chk_v("sweep_writes_outstanding", mq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end else if (cyc_n > 2000) begin
      checks++;
      failures++;
      $display("FAIL timeout: stimulus not done after %0d cycles", cyc_n);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  // Close the current cycle's expectations and move to the next cycle
  task automatic go(input logic [2:0] g, input logic b);
    exp_g = g;
    exp_b = b;
    chk_g = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_v(input logic d);
    vq.push_back('{d: d, due: cyc_n + 2});
  endtask

  task automatic push_e(input logic d);
    eq.push_back('{d: d, due: cyc_n + 2});
  endtask

  initial begin
    bus.clear_grid = 0; bus.vga_req = 0; bus.vga_addr = '0;
    bus.edit_req = 0; bus.edit_addr = '0; bus.edit_wdata = 0;
    bus.eng_req = 0; bus.eng_we = 0; bus.eng_addr = '0; bus.eng_wdata = 0;

    // Reset state
    chk_rst = 1; chk_m = 1; exp_m = 2'b00; exp_a = '0;
    repeat (3) go(3'b000, 0);
    rst = 0;
    go(3'b000, 0);
    chk_rst = 0; chk_m = 0;

    // Full sweep; VGA waits through it
    bus.clear_grid = 1;
    for (int i = 0; i < 8; i++) mq.push_back(i);
    go(3'b000, 0);
    bus.clear_grid = 0; bus.vga_req = 1; bus.vga_addr = 4'd3;
    repeat (8) go(3'b000, 1);
    push_v(1'b0);
    go(3'b100, 0);
    bus.vga_req = 0;
    go(3'b000, 0);

    // Fixed priority VGA > edit > engine; engine reads back edit's write
    chk_m = 1;
    bus.vga_req = 1; bus.vga_addr = 4'd10;
    bus.edit_req = 1; bus.edit_addr = 4'd5; bus.edit_wdata = 1;
    bus.eng_req = 1; bus.eng_we = 0; bus.eng_addr = 4'd5;
    push_v(1'b1); exp_m = 2'b10; exp_a = 4'd10;
    go(3'b100, 0);
    bus.vga_req = 0; exp_m = 2'b11; exp_a = 4'd5;
    go(3'b010, 0);
    bus.edit_req = 0; exp_m = 2'b10; exp_a = 4'd5;
    push_e(1'b1);
    go(3'b001, 0);
    bus.eng_req = 0; exp_m = 2'b00; exp_a = 4'd5;
    go(3'b000, 0);
    chk_m = 0;

    // Starvation: engine wins on its 9th requesting cycle
    bus.vga_req = 1; bus.vga_addr = 4'd12;
    bus.eng_req = 1; bus.eng_we = 0; bus.eng_addr = 4'd0;
    for (int i = 0; i < 8; i++) begin
      push_v(1'b1);
      go(3'b100, 0);
    end
    push_e(1'b0);
    go(3'b001, 0);
    push_v(1'b1);
    go(3'b100, 0);
    bus.vga_req = 0; bus.eng_req = 0;
    go(3'b000, 0);

    // Back-to-back VGA reads with distinct data
    bus.edit_req = 1; bus.edit_addr = 4'd11; bus.edit_wdata = 0;
    go(3'b010, 0);
    bus.edit_req = 0; bus.vga_req = 1;
    bus.vga_addr = 4'd10; push_v(1'b1); go(3'b100, 0);
    bus.vga_addr = 4'd11; push_v(1'b0); go(3'b100, 0);
    bus.vga_addr = 4'd12; push_v(1'b1); go(3'b100, 0);
    bus.vga_req = 0;
    go(3'b000, 0);

    // Engine write: no rvalid, then VGA sees the new value
    bus.eng_req = 1; bus.eng_we = 1; bus.eng_addr = 4'd12; bus.eng_wdata = 0;
    go(3'b001, 0);
    bus.eng_req = 0; bus.eng_we = 0;
    go(3'b000, 0);
    bus.vga_req = 1; bus.vga_addr = 4'd12; push_v(1'b0);
    go(3'b100, 0);
    bus.vga_req = 0;
    go(3'b000, 0);

    // Restart at pointer 3, then reset aborts at pointer 2
    bus.clear_grid = 1;
    mq.push_back(0); mq.push_back(1); mq.push_back(2); mq.push_back(3);
    mq.push_back(0); mq.push_back(1);
    go(3'b000, 0);
    bus.clear_grid = 0;
    repeat (3) go(3'b000, 1);
    bus.clear_grid = 1;
    go(3'b000, 1);
    bus.clear_grid = 0;
    repeat (2) go(3'b000, 1);
    rst = 1; chk_rst = 1; chk_m = 1; exp_m = 2'b00; exp_a = '0;
    go(3'b000, 0);
    go(3'b000, 0);
    rst = 0;
    go(3'b000, 0);
    go(3'b000, 0);
    chk_rst = 0; chk_m = 0;

    done = 1;
    forever @(posedge clk);
  end
endmodule
